// File: rtl/debug_regfile_dumper.sv
// Walks every register of the debug regfile on request and streams each
// 32-bit frame MSB-byte-first onto a valid/ready byte interface.
module debug_regfile_dumper #(
  parameter int         NB_FRAME    = 32,
  parameter int         NB_BYTE     = 8,
  parameter int         N_REGS      = 32,
  parameter int         NB_ADDR     = 5,
  parameter logic [5:0] SELECT_IDLE = 6'b10_0000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_FRAME-1:0] i_frame_from_ctrl,
  input  logic                i_tx_ready,
  output logic [5:0]          o_request_select,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_valid,
  output logic                o_busy,
  output logic                o_done
);

  localparam int N_BYTES = NB_FRAME / NB_BYTE;
  localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(N_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SEND,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NB_ADDR-1:0]  addr_q, addr_d;
  logic [NB_CNT-1:0]   byte_cnt_q, byte_cnt_d;
  logic [NB_FRAME-1:0] shift_q, shift_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = SELECT;
          addr_d  = '0;
        end
      end
      SELECT: begin
        // The controller answers combinationally, so the frame is valid in the select cycle.
        shift_d    = i_frame_from_ctrl;
        byte_cnt_d = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (i_tx_ready) begin
          shift_d    = shift_q << NB_BYTE;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            if (addr_q == LAST_ADDR) begin
              state_d = DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = SELECT;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Outputs decode only flopped state, so an async reset clears them at once.
  always_comb begin
    o_request_select = (state_q == SELECT) ? 6'(addr_q) : SELECT_IDLE;
    o_tx_valid       = (state_q == SEND);
    o_tx_data        = (state_q == SEND) ? shift_q[NB_FRAME-1 -: NB_BYTE] : '0;
    o_busy           = (state_q != IDLE);
    o_done           = (state_q == DONE);
  end

endmodule

// File: tb/tb_debug_regfile_dumper.sv
// Directed bench for debug_regfile_dumper: models the regfile controller and
// checks select order, byte stream, handshake stability, reset and restart.
module tb_debug_regfile_dumper;

  logic        i_clock;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_frame_from_ctrl;
  logic        i_tx_ready;
  logic [5:0]  o_request_select;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_done;

  int vectors     = 0;
  int miscompares = 0;

  int doneCyc;
  int bytesSeen;
  int selsSeen;
  int doneSeen;

  debug_regfile_dumper dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_frame_from_ctrl(i_frame_from_ctrl),
    .i_tx_ready       (i_tx_ready),
    .o_request_select (o_request_select),
    .o_tx_data        (o_tx_data),
    .o_tx_valid       (o_tx_valid),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Regfile controller model: frame for register n is A0B1C2D0+n, junk when unselected.
  assign i_frame_from_ctrl = o_request_select[5] ? 32'hDEAD_BEEF
                                                 : 32'hA0B1_C2D0 + {27'd0, o_request_select[4:0]};

  function automatic logic [7:0] expByte(input int idx);
    logic [31:0] frame;
    int          k;
    frame = 32'hA0B1_C2D0 + 32'(idx / 4);
    k     = idx % 4;
    return frame[31 - 8*k -: 8];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one dump cycle by cycle, starting the negedge after the start edge.
  task automatic applyStimulus(input bit rndReady, input bit holdStart, input int extraStartCyc,
                               input int abortAtByte, output int dCyc, output int nBytes,
                               output int nSels, output int nDone);
    int  idx;
    bit  prevStall;
    bit  rdy;
    idx       = 0;
    prevStall = 1'b0;
    dCyc      = -1;
    nSels     = 0;
    nDone     = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge i_clock);
      i_start = holdStart || (cyc == extraStartCyc);
      checkOutput("busy", {31'd0, o_busy}, 32'd1);
      if (o_request_select !== 6'h20) begin
        checkOutput("select", {26'd0, o_request_select}, 32'(nSels));
        nSels++;
      end
      if (prevStall) checkOutput("valid_hold", {31'd0, o_tx_valid}, 32'd1);
      if (o_tx_valid) checkOutput("tx_data", {24'd0, o_tx_data}, {24'd0, expByte(idx)});
      if (abortAtByte >= 0 && idx == abortAtByte && o_tx_valid) begin
        nBytes = idx;
        return;
      end
      if (o_done) begin
        nDone++;
        dCyc = cyc;
        checkOutput("done_valid", {31'd0, o_tx_valid}, 32'd0);
        break;
      end
      rdy        = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      i_tx_ready = rdy;
      prevStall  = o_tx_valid && !rdy;
      if (o_tx_valid && rdy) idx++;
    end
    nBytes = idx;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    checkOutput({tag, "_select"}, {26'd0, o_request_select}, 32'h20);
    checkOutput({tag, "_valid"}, {31'd0, o_tx_valid}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_tx_ready = 1'b1;
    #3;
    checkIdle("reset");
    checkOutput("reset_data", {24'd0, o_tx_data}, 32'd0);
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    checkIdle("post_reset");

    $display("[TB] step 1: full dump with ready tied high");
    i_start = 1'b1;
    applyStimulus(1'b0, 1'b0, -1, -1, doneCyc, bytesSeen, selsSeen, doneSeen);
    checkOutput("t1_done_cycle", 32'(doneCyc), 32'd161);
    checkOutput("t1_bytes", 32'(bytesSeen), 32'd128);
    checkOutput("t1_selects", 32'(selsSeen), 32'd32);
    @(negedge i_clock);
    checkIdle("t1_after");

    $display("[TB] step 2: random backpressure");
    i_start = 1'b1;
    applyStimulus(1'b1, 1'b0, -1, -1, doneCyc, bytesSeen, selsSeen, doneSeen);
    checkOutput("t2_done_seen", 32'(doneSeen), 32'd1);
    checkOutput("t2_bytes", 32'(bytesSeen), 32'd128);
    checkOutput("t2_selects", 32'(selsSeen), 32'd32);
    i_tx_ready = 1'b1;
    @(negedge i_clock);
    checkIdle("t2_after");

    $display("[TB] step 4: start pulse during SEND of reg 5 is ignored");
    i_start = 1'b1;
    applyStimulus(1'b0, 1'b0, 28, -1, doneCyc, bytesSeen, selsSeen, doneSeen);
    checkOutput("t4_done_cycle", 32'(doneCyc), 32'd161);
    checkOutput("t4_bytes", 32'(bytesSeen), 32'd128);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clock);
      checkIdle("t4_not_queued");
    end

    $display("[TB] step 5: reset mid-dump at reg 10 byte 2");
    i_start = 1'b1;
    applyStimulus(1'b0, 1'b0, -1, 42, doneCyc, bytesSeen, selsSeen, doneSeen);
    checkOutput("t5_abort_point", 32'(bytesSeen), 32'd42);
    checkOutput("t5_pre_valid", {31'd0, o_tx_valid}, 32'd1);
    #2 i_reset = 1'b1;
    #1;
    checkIdle("t5_async");
    checkOutput("t5_async_data", {24'd0, o_tx_data}, 32'd0);
    @(negedge i_clock);
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clock);
      checkIdle("t5_wait_start");
    end
    i_start = 1'b1;
    applyStimulus(1'b0, 1'b0, -1, -1, doneCyc, bytesSeen, selsSeen, doneSeen);
    checkOutput("t5_restart_done", 32'(doneCyc), 32'd161);
    checkOutput("t5_restart_bytes", 32'(bytesSeen), 32'd128);
    @(negedge i_clock);
    checkIdle("t5_after");

    $display("[TB] step 6: start held high gives back-to-back dumps");
    i_start = 1'b1;
    applyStimulus(1'b0, 1'b1, -1, -1, doneCyc, bytesSeen, selsSeen, doneSeen);
    checkOutput("t6_first_done", 32'(doneCyc), 32'd161);
    @(negedge i_clock);
    checkIdle("t6_gap");
    applyStimulus(1'b0, 1'b1, -1, -1, doneCyc, bytesSeen, selsSeen, doneSeen);
    checkOutput("t6_second_done", 32'(doneCyc), 32'd161);
    checkOutput("t6_second_bytes", 32'(bytesSeen), 32'd128);
    @(negedge i_clock);
    i_start = 1'b0;
    checkIdle("t6_gap2");
    @(negedge i_clock);
    checkIdle("t6_stopped");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
